// File: rtl/control_unit_if.sv
// control_unit_if: program/data memory and datapath control bus of the control unit.
// master = control unit, slave = memories and accumulator datapath.
interface control_unit_if;
    logic [7:0]  pm_addr;
    logic [15:0] pm_data;
    logic [7:0]  dm_addr;
    logic        dm_re;
    logic [7:0]  acumulator;
    logic        acumulator_ce;
    logic [2:0]  operation_code;
    logic [2:0]  register_file_ce;
    logic [1:0]  register_file_mux_addr;
    logic        data_memory_read_enable;
    logic [7:0]  direct_data;
    logic        direct_load;
    modport master (
        output pm_addr, dm_addr, dm_re, acumulator_ce, operation_code, register_file_ce,
               register_file_mux_addr, data_memory_read_enable, direct_data, direct_load,
        input  pm_data, acumulator
    );
    modport slave (
        input  pm_addr, dm_addr, dm_re, acumulator_ce, operation_code, register_file_ce,
               register_file_mux_addr, data_memory_read_enable, direct_data, direct_load,
        output pm_data, acumulator
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: fetches/decodes 16-bit instructions and pulses accumulator datapath controls in EXEC.
// Define CONTROL_UNIT_JZ_EN to make opcode 0x6 a jump-if-accumulator-zero; otherwise it decodes as NOP.
module control_unit (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    control_unit_if.master bus,
    output logic           o_busy,
    output logic           o_halted
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, MEM, EXEC, HALT} state_t;
    state_t      state;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [15:0] nx;
    logic [3:0]  opc;
    logic        enter_mem;
    logic        enter_exec;
    logic        jz_taken;
    logic        jump;
    logic        unused;
    // Controls are registered on the way into EXEC: from the fetched word in DECODE, from IR in MEM.
    assign nx = state == MEM ? ir : bus.pm_data;
    assign opc = nx[15:12];
    assign enter_mem = state == DECODE && opc == 4'h2;
    assign enter_exec = state == MEM || (state == DECODE && opc != 4'h2 && opc != 4'hF);
`ifdef CONTROL_UNIT_JZ_EN
    assign jz_taken = ir[15:12] == 4'h6 && bus.acumulator == 8'h00;
    assign unused = ir[8];
`else
    assign jz_taken = 1'b0;
    assign unused = ^{ir[8], bus.acumulator};
`endif
    assign jump = state == EXEC && (ir[15:12] == 4'h5 || jz_taken);
    assign bus.pm_addr = pc;
    assign o_busy = state inside {FETCH, DECODE, MEM, EXEC};
    assign o_halted = state == HALT;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            pc <= '0;
            ir <= '0;
            bus.dm_addr <= '0;
            bus.dm_re <= 1'b0;
            bus.acumulator_ce <= 1'b0;
            bus.operation_code <= 3'b110;
            bus.register_file_ce <= 3'b000;
            bus.register_file_mux_addr <= 2'b00;
            bus.data_memory_read_enable <= 1'b0;
            bus.direct_data <= 8'h00;
            bus.direct_load <= 1'b0;
        end else begin
            bus.dm_re <= enter_mem;
            bus.dm_addr <= enter_mem || enter_exec ? nx[7:0] : 8'h00;
            bus.acumulator_ce <= enter_exec && opc inside {4'h1, 4'h2, 4'h3};
            bus.operation_code <= enter_exec && (opc == 4'h1 || opc == 4'h2) ? nx[11:9] : 3'b110;
            bus.register_file_ce <= enter_exec && opc == 4'h4 ? {1'b0, nx[1:0]} : 3'b000;
            bus.register_file_mux_addr <= enter_exec && opc == 4'h1 ? nx[1:0] : 2'b00;
            bus.data_memory_read_enable <= enter_exec && opc == 4'h2;
            bus.direct_data <= enter_exec && opc == 4'h3 ? nx[7:0] : 8'h00;
            bus.direct_load <= enter_exec && opc == 4'h3;
            case (state)
                IDLE, HALT: begin
                    if (i_start) begin
                        state <= FETCH;
                        pc <= '0;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    ir <= bus.pm_data;
                    pc <= pc + 8'd1;
                    state <= enter_mem ? MEM : enter_exec ? EXEC : HALT;
                end
                MEM: state <= EXEC;
                EXEC: begin
                    state <= FETCH;
                    if (jump) pc <= ir[7:0];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed tests of the control unit against a synchronous program memory model.
module tb_control_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        halted;
    logic [15:0] pm [256];
    logic [18:0] ctl;
    int          n_chk = 0;
    int          n_fail = 0;
    localparam logic [18:0] DEF = {1'b0, 3'b110, 3'b000, 2'b00, 1'b0, 8'h00, 1'b0};
`ifdef CONTROL_UNIT_JZ_EN
    localparam logic [7:0] JZ_TARGET = 8'h20;
`else
    localparam logic [7:0] JZ_TARGET = 8'h01;
`endif

    control_unit_if bus();
    control_unit dut (.i_clk(clk), .i_rst(rst), .i_start(start), .bus(bus), .o_busy(busy), .o_halted(halted));

    always #5 clk = ~clk;
    always @(posedge clk) bus.pm_data <= pm[bus.pm_addr];
    assign ctl = {bus.acumulator_ce, bus.operation_code, bus.register_file_ce, bus.register_file_mux_addr,
                  bus.data_memory_read_enable, bus.direct_data, bus.direct_load};

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_pm();
        for (int i = 0; i < 256; i++) pm[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    // Leaves the bench at the negedge inside the FETCH cycle of address 0 (cycle 1).
    task automatic start_prog();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        step(3);
        n_chk++; if (ctl !== DEF) begin n_fail++; $display("FAIL reset_ctl: got %h want %h", ctl, DEF); end
        n_chk++; if ({busy, halted, bus.pm_addr, bus.dm_addr, bus.dm_re} !== 19'h0) begin n_fail++; $display("FAIL reset_status: got %b%b %h %h %b want all zero", busy, halted, bus.pm_addr, bus.dm_addr, bus.dm_re); end
        start = 1'b0;
        rst = 1'b0;
        step(2);
        n_chk++; if ({busy, halted} !== 2'b00) begin n_fail++; $display("FAIL reset_idle: got %b%b want 00", busy, halted); end
    endtask

    task automatic test_ldi_halt();
        clear_pm();
        pm[0] = 16'h3005;
        pm[1] = 16'hF000;
        do_reset();
        start_prog();
        n_chk++; if ({busy, bus.pm_addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL ldi_fetch: got %b %h want 1 00", busy, bus.pm_addr); end
        step(1);
        n_chk++; if (ctl !== DEF) begin n_fail++; $display("FAIL ldi_early: got %h want %h", ctl, DEF); end
        step(1);
        n_chk++; if (ctl !== {1'b1, 3'b110, 3'b000, 2'b00, 1'b0, 8'h05, 1'b1}) begin n_fail++; $display("FAIL ldi_exec: got %h", ctl); end
        step(1);
        n_chk++; if ({ctl, bus.pm_addr} !== {DEF, 8'h01}) begin n_fail++; $display("FAIL ldi_one_cycle: got %h %h want %h 01", ctl, bus.pm_addr, DEF); end
        step(1);
        n_chk++; if ({busy, halted} !== 2'b10) begin n_fail++; $display("FAIL halt_early: got %b%b want 10", busy, halted); end
        step(1);
        n_chk++; if ({busy, halted} !== 2'b01) begin n_fail++; $display("FAIL halt: got %b%b want 01", busy, halted); end
    endtask

    task automatic test_back_to_back();
        start_prog();
        n_chk++; if ({busy, halted, bus.pm_addr} !== {2'b10, 8'h00}) begin n_fail++; $display("FAIL restart_fetch: got %b%b %h want 10 00", busy, halted, bus.pm_addr); end
        step(2);
        n_chk++; if (ctl !== {1'b1, 3'b110, 3'b000, 2'b00, 1'b0, 8'h05, 1'b1}) begin n_fail++; $display("FAIL restart_ldi: got %h", ctl); end
    endtask

    task automatic test_alu();
        clear_pm();
        pm[0] = 16'h1002;
        pm[1] = 16'h2840;
        pm[2] = 16'hF000;
        do_reset();
        start_prog();
        step(2);
        n_chk++; if (ctl !== {1'b1, 3'b000, 3'b000, 2'b10, 1'b0, 8'h00, 1'b0}) begin n_fail++; $display("FAIL alur_exec: got %h", ctl); end
        step(1);
        n_chk++; if (ctl !== DEF) begin n_fail++; $display("FAIL alur_one_cycle: got %h want %h", ctl, DEF); end
        step(2);
        n_chk++; if ({bus.dm_re, bus.dm_addr, ctl, busy} !== {1'b1, 8'h40, DEF, 1'b1}) begin n_fail++; $display("FAIL alum_mem: got re=%b addr=%h ctl=%h busy=%b", bus.dm_re, bus.dm_addr, ctl, busy); end
        step(1);
        n_chk++; if (ctl !== {1'b1, 3'b100, 3'b000, 2'b00, 1'b1, 8'h00, 1'b0}) begin n_fail++; $display("FAIL alum_exec: got %h", ctl); end
        n_chk++; if ({bus.dm_re, bus.dm_addr} !== {1'b0, 8'h40}) begin n_fail++; $display("FAIL alum_addr: got re=%b addr=%h want 0 40", bus.dm_re, bus.dm_addr); end
        step(1);
        n_chk++; if ({ctl, bus.dm_addr, bus.pm_addr} !== {DEF, 8'h00, 8'h02}) begin n_fail++; $display("FAIL alum_after: got %h %h %h", ctl, bus.dm_addr, bus.pm_addr); end
    endtask

    task automatic test_str();
        clear_pm();
        pm[0] = 16'h4003;
        pm[1] = 16'h4000;
        pm[2] = 16'hF000;
        do_reset();
        start_prog();
        step(2);
        n_chk++; if (ctl !== {1'b0, 3'b110, 3'b011, 2'b00, 1'b0, 8'h00, 1'b0}) begin n_fail++; $display("FAIL str_r3: got %h", ctl); end
        step(1);
        n_chk++; if (ctl !== DEF) begin n_fail++; $display("FAIL str_one_cycle: got %h want %h", ctl, DEF); end
        step(2);
        n_chk++; if ({ctl, busy} !== {DEF, 1'b1}) begin n_fail++; $display("FAIL str_r0: got %h busy=%b want %h 1", ctl, busy, DEF); end
        step(1);
        n_chk++; if (bus.pm_addr !== 8'h02) begin n_fail++; $display("FAIL str_next: got %h want 02", bus.pm_addr); end
    endtask

    task automatic test_jz();
        clear_pm();
        pm[0] = 16'h6020;
        pm[1] = 16'hF000;
        pm[8'h20] = 16'hF000;
        bus.acumulator = 8'h00;
        do_reset();
        start_prog();
        step(2);
        n_chk++; if (ctl !== DEF) begin n_fail++; $display("FAIL jz_ctl: got %h want %h", ctl, DEF); end
        step(1);
        n_chk++; if (bus.pm_addr !== JZ_TARGET) begin n_fail++; $display("FAIL jz_zero: got %h want %h", bus.pm_addr, JZ_TARGET); end
        bus.acumulator = 8'h01;
        do_reset();
        start_prog();
        step(3);
        n_chk++; if (bus.pm_addr !== 8'h01) begin n_fail++; $display("FAIL jz_nonzero: got %h want 01", bus.pm_addr); end
        bus.acumulator = 8'h00;
    endtask

    task automatic test_reset_mid();
        logic bad;
        clear_pm();
        pm[0] = 16'h2040;
        do_reset();
        start_prog();
        step(2);
        n_chk++; if ({bus.dm_re, bus.dm_addr} !== {1'b1, 8'h40}) begin n_fail++; $display("FAIL mid_mem: got re=%b addr=%h want 1 40", bus.dm_re, bus.dm_addr); end
        rst = 1'b1;
        #1;
        n_chk++; if (ctl !== DEF) begin n_fail++; $display("FAIL mid_ctl: got %h want %h", ctl, DEF); end
        n_chk++; if ({busy, halted, bus.pm_addr, bus.dm_addr, bus.dm_re} !== 19'h0) begin n_fail++; $display("FAIL mid_status: got %b%b %h %h %b want all zero", busy, halted, bus.pm_addr, bus.dm_addr, bus.dm_re); end
        @(negedge clk) rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bad = bad | bus.acumulator_ce | busy;
        end
        n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL mid_no_pulse: got %b want 0", bad); end
    endtask

    task automatic test_jmp_wrap();
        clear_pm();
        pm[0] = 16'h50FF;
        pm[8'hFF] = 16'h0000;
        do_reset();
        start_prog();
        step(3);
        n_chk++; if (bus.pm_addr !== 8'hFF) begin n_fail++; $display("FAIL jmp_target: got %h want ff", bus.pm_addr); end
        step(3);
        n_chk++; if (bus.pm_addr !== 8'h00) begin n_fail++; $display("FAIL pc_wrap: got %h want 00", bus.pm_addr); end
        do_reset();
    endtask

    initial begin
        bus.acumulator = 8'h00;
        clear_pm();
        test_reset();
        test_ldi_halt();
        test_back_to_back();
        test_alu();
        test_str();
        test_jz();
        test_reset_mid();
        test_jmp_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
